// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_seq
// Brief    : Registered N-to-2^N one-hot decoder, valid/ready direct mode
//            plus an autonomous scan mode for multiplexed select lines.
// Revision : 1.0  initial release
// ============================================================================
module onehot_decoder_seq #(
    parameter int N          = 2,
    parameter int SCAN_DIV   = 4,
    parameter bit REVERSE    = 1'b0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic                in_valid_i,
    input  logic [N-1:0]        in_code_i,
    output logic                in_ready_o,
    input  logic                out_ready_i,
    output logic                out_valid_o,
    output logic [N-1:0]        out_index_o,
    output logic [(2**N)-1:0]   out_onehot_o
);

    localparam int OUT_W = 2**N;
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [0:0]    S_DIRECT   = 1'b0;
    localparam logic [0:0]    S_SCAN     = 1'b1;
    localparam logic [PW-1:0] C_DIV_LAST = PW'(SCAN_DIV - 1);

    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     index_q, index_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             accept_w;
    logic [N-1:0]     pos_w;
    logic [OUT_W-1:0] onehot_w;

    assign in_ready_o = enable_i && (state_q == S_DIRECT) && !mode_i
                        && (!valid_q || out_ready_i);
    assign accept_w   = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        index_d = index_q;
        presc_d = presc_q;
        // A disabled edge leaves every register untouched, mode included.
        if (enable_i) begin
            case (state_q)
                S_DIRECT: begin
                    if (mode_i) begin
                        state_d = S_SCAN;
                        index_d = '0;
                        presc_d = '0;
                        valid_d = 1'b1;
                    end else if (accept_w) begin
                        index_d = in_code_i;
                        valid_d = 1'b1;
                    end else if (valid_q && out_ready_i) begin
                        valid_d = 1'b0;
                    end
                end
                S_SCAN: begin
                    if (!mode_i) begin
                        state_d = S_DIRECT;
                        valid_d = 1'b0;
                    end else if (presc_q == C_DIV_LAST) begin
                        presc_d = '0;
                        index_d = index_q + N'(1);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = S_DIRECT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DIRECT;
            valid_q <= 1'b0;
            index_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            index_q <= index_d;
            presc_q <= presc_d;
        end
    end

    // Reversed mapping k -> OUT_W-1-k is a bitwise inversion of the index.
    assign pos_w = REVERSE ? ~index_q : index_q;

    always_comb begin
        onehot_w = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot_w[i] = (pos_w == N'(i));
        end
    end

    assign out_valid_o  = enable_i && valid_q;
    assign out_index_o  = index_q;
    assign out_onehot_o = (out_valid_o ? onehot_w : '0) ^ {OUT_W{ACTIVE_LOW}};

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_decoder_seq
// Brief    : Directed self-checking bench; plain and reversed/active-low
//            instances share one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_onehot_decoder_seq;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic       mode_i;
    logic       in_valid_i;
    logic [1:0] in_code_i;
    logic       out_ready_i;

    logic       a_in_ready, b_in_ready;
    logic       a_out_valid, b_out_valid;
    logic [1:0] a_out_index, b_out_index;
    logic [3:0] a_onehot, b_onehot;

    int n_checks = 0;
    int n_errors = 0;

    onehot_decoder_seq #(.N(2), .SCAN_DIV(3), .REVERSE(1'b0), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .in_valid_i   (in_valid_i),
        .in_code_i    (in_code_i),
        .in_ready_o   (a_in_ready),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (a_out_valid),
        .out_index_o  (a_out_index),
        .out_onehot_o (a_onehot)
    );

    onehot_decoder_seq #(.N(2), .SCAN_DIV(3), .REVERSE(1'b1), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .in_valid_i   (in_valid_i),
        .in_code_i    (in_code_i),
        .in_ready_o   (b_in_ready),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (b_out_valid),
        .out_index_o  (b_out_index),
        .out_onehot_o (b_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        enable_i    = 1'b1;
        mode_i      = 1'b0;
        in_valid_i  = 1'b0;
        in_code_i   = 2'd0;
        out_ready_i = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Load a word so the asynchronous reset has something to clear.
        in_valid_i  = 1'b1;
        in_code_i   = 2'd2;
        tick();
        chk("preload_onehot", 32'(a_onehot), 32'h4);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_onehot_a", 32'(a_onehot), 32'h0);
        chk("rst_valid_a", 32'(a_out_valid), 32'h0);
        chk("rst_index_a", 32'(a_out_index), 32'h0);
        chk("rst_onehot_b", 32'(b_onehot), 32'hF);
        rst         = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'h1);
        tick();

        // Direct sweep, one code per cycle.
        in_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_code_i = 2'(c);
            tick();
            chk("sweep_onehot_a", 32'(a_onehot), 32'(4'b0001 << c));
            chk("sweep_valid_a", 32'(a_out_valid), 32'h1);
            chk("sweep_onehot_b", 32'(b_onehot), 32'(~(4'b1000 >> c) & 4'hF));
        end
        in_valid_i = 1'b0;
        tick();
        chk("drain_valid", 32'(a_out_valid), 32'h0);
        chk("drain_onehot_a", 32'(a_onehot), 32'h0);
        chk("idle_onehot_b", 32'(b_onehot), 32'hF);

        // Backpressure: code 1 held while a competing code waits.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_code_i   = 2'd1;
        tick();
        in_code_i   = 2'd2;
        for (int k = 0; k < 5; k++) begin
            chk("bp_onehot", 32'(a_onehot), 32'h2);
            chk("bp_valid", 32'(a_out_valid), 32'h1);
            chk("bp_in_ready", 32'(a_in_ready), 32'h0);
            tick();
        end
        out_ready_i = 1'b1;
        in_code_i   = 2'd3;
        #1;
        chk("bp_release_ready", 32'(a_in_ready), 32'h1);
        tick();
        chk("bp_new_onehot", 32'(a_onehot), 32'h8);
        chk("bp_new_valid", 32'(a_out_valid), 32'h1);
        in_valid_i = 1'b0;
        tick();

        // Scan with SCAN_DIV=3: each index held three cycles, then wrap.
        mode_i = 1'b1;
        tick();
        chk("scan_in_ready", 32'(a_in_ready), 32'h0);
        for (int k = 0; k < 13; k++) begin
            chk("scan_onehot", 32'(a_onehot), 32'(4'b0001 << ((k / 3) % 4)));
            chk("scan_valid", 32'(a_out_valid), 32'h1);
            tick();
        end
        // Now index 0 with prescaler 1; freeze for four edges.
        enable_i = 1'b0;
        #1;
        chk("frz_onehot_a", 32'(a_onehot), 32'h0);
        chk("frz_valid", 32'(a_out_valid), 32'h0);
        chk("frz_in_ready", 32'(a_in_ready), 32'h0);
        chk("frz_onehot_b", 32'(b_onehot), 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("frz_hold_onehot", 32'(a_onehot), 32'h0);
            chk("frz_hold_index", 32'(a_out_index), 32'h0);
        end
        enable_i = 1'b1;
        #1;
        chk("resume_onehot0", 32'(a_onehot), 32'h1);
        tick();
        chk("resume_onehot1", 32'(a_onehot), 32'h1);
        tick();
        chk("resume_onehot2", 32'(a_onehot), 32'h2);
        chk("resume_index2", 32'(a_out_index), 32'h1);

        // Leave scan.
        mode_i = 1'b0;
        tick();
        chk("exit_valid", 32'(a_out_valid), 32'h0);
        chk("exit_onehot", 32'(a_onehot), 32'h0);
        chk("exit_in_ready", 32'(a_in_ready), 32'h1);

        // Reset in the middle of a scan.
        mode_i = 1'b1;
        repeat (4) tick();
        chk("scan2_onehot", 32'(a_onehot), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("scan_rst_onehot", 32'(a_onehot), 32'h0);
        chk("scan_rst_valid", 32'(a_out_valid), 32'h0);
        chk("scan_rst_index", 32'(a_out_index), 32'h0);
        mode_i = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(a_out_valid), 32'h0);
        chk("post_rst_onehot", 32'(a_onehot), 32'h0);
        mode_i = 1'b1;
        tick();
        chk("restart_onehot", 32'(a_onehot), 32'h1);
        chk("restart_index", 32'(a_out_index), 32'h0);
        chk("restart_onehot_b", 32'(b_onehot), 32'h7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
